program_flow_unit: RTL
======================

PROGRAM_FLOW_UNIT -- requirements
Module: program_flow_unit

Interface
REQ-001 Parameter PC_W, default 11, program counter width in bits.
REQ-002 Parameter DEPTH, default 8, return-stack entry count (power of 2, >=2).
REQ-003 Parameter RESET_VEC, default 0, PC value after reset and after an underflowing pop.
REQ-004 Parameter INT_VEC, default 4, PC value loaded when an interrupt is taken.
REQ-005 Port clk  input  1  clock; all state updates on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port cmd_valid  input  1  command strobe, one command per asserted cycle.
REQ-008 Port cmd  input  3  0 NEXT, 1 GOTO, 2 CALL, 3 RETURN, 4 BRA, 5 SKIP, 6 RETFIE, 7 reserved.
REQ-009 Port target  input  PC_W  absolute destination for GOTO/CALL.
REQ-010 Port offset  input  PC_W  two's-complement displacement for BRA.
REQ-011 Port skip_cond  input  1  SKIP condition, sampled with cmd_valid.
REQ-012 Port int_req  input  1  level interrupt request.
REQ-013 Port int_en  input  1  global interrupt enable.
REQ-014 Port clr_err  input  1  clears sticky error flags.
REQ-015 Port pc  output  PC_W  current program counter (registered).
REQ-016 Port flush  output  1  one-cycle pulse: pc changed non-sequentially; pipeline must discard fetched word.
REQ-017 Port level  output  $clog2(DEPTH+1)  occupied stack entries, 0..DEPTH.
REQ-018 Port int_active  output  1  interrupt service in progress.
REQ-019 Port stack_ovf  output  1  sticky push-while-full flag.
REQ-020 Port stack_unf  output  1  sticky pop-while-empty flag.

Function
REQ-021 Cycles with cmd_valid=0 SHALL hold pc, stack, level and flags unchanged; flush=0.
REQ-022 All pc results SHALL update on the edge after the cmd_valid cycle; flush SHALL be high exactly the cycle the new pc is first visible.
REQ-023 NEXT and reserved cmd 7 SHALL load pc+1, flush=0.
REQ-024 GOTO SHALL load target, flush=1.
REQ-025 CALL SHALL push pc+1 and load target, flush=1.
REQ-026 RETURN SHALL pop top entry into pc, flush=1.
REQ-027 BRA SHALL load pc+1+offset, flush=1.
REQ-028 SKIP SHALL load pc+2 with flush=1 if skip_cond=1, else pc+1 with flush=0.
REQ-029 RETFIE SHALL behave as RETURN and clear int_active in the same edge.
REQ-030 All pc arithmetic SHALL wrap modulo 2^PC_W.
REQ-031 Stack SHALL be circular: push when level=DEPTH overwrites oldest entry, level stays DEPTH, stack_ovf set.
REQ-032 Pop when level=0 SHALL load RESET_VEC, level stays 0, stack_unf set.
REQ-033 Interrupt taken when cmd_valid=1, int_req=1, int_en=1, int_active=0, cmd in {NEXT, GOTO, BRA, SKIP, 7}: the command's computed next pc is pushed, pc=INT_VEC, int_active=1, flush=1.
REQ-034 Interrupt coinciding with CALL, RETURN or RETFIE SHALL be deferred; command executes normally; interrupt re-evaluated at next cmd_valid.
REQ-035 Interrupt push SHALL obey REQ-031 overflow rules.
REQ-036 clr_err SHALL clear stack_ovf/stack_unf; a same-cycle set event SHALL win over clr_err.
REQ-037 Command latency SHALL be 1 cycle; back-to-back cmd_valid every cycle SHALL be supported.

Reset
REQ-038 rst SHALL force pc=RESET_VEC, level=0, int_active=0, flush=0, stack_ovf=0, stack_unf=0; stack contents need not clear.
REQ-039 rst SHALL override any same-cycle command, interrupt or clr_err, including mid-interrupt service.

Verification
REQ-040 Reset, then 3 NEXT -> pc 0,1,2,3; flush never high.
REQ-041 pc=5, CALL target=0x100, then RETURN -> pc=0x100 flush=1 level=1, then pc=6 flush=1 level=0.
REQ-042 pc=0x7FF (PC_W=11), NEXT -> pc=0x000; pc=0x010, BRA offset=0x7FE -> pc=0x00F.
REQ-043 9 CALLs (DEPTH=8) -> level=8, stack_ovf=1; 8 RETURNs -> 8 pops in LIFO order ending at second call's return address; extra RETURN -> pc=0, stack_unf=1; clr_err -> both flags 0.
REQ-044 pc=0x20, int_req=int_en=1 with SKIP skip_cond=1 -> pc=4, int_active=1, stack top=0x22; RETFIE -> pc=0x22, int_active=0.
REQ-045 int_req=1 concurrent with CALL target=0x40 at pc=0x10 -> pc=0x40, int_active=0; next NEXT -> pc=4, stack top=0x41, level=2.

Source files
------------

// File: rtl/program_flow_unit.sv
// program_flow_unit
//   Program counter sequencer with a circular return-address stack and a
//   single-level interrupt entry/exit mechanism.
//
//   Parameters
//     PC_W      program counter width
//     DEPTH     return-stack entries (power of 2, >= 2)
//     RESET_VEC pc after reset and after popping an empty stack
//     INT_VEC   pc loaded when an interrupt is taken
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     cmd_valid, cmd    command strobe and opcode
//                       (0 NEXT, 1 GOTO, 2 CALL, 3 RETURN, 4 BRA, 5 SKIP,
//                        6 RETFIE, 7 reserved = NEXT)
//     target            absolute destination for GOTO/CALL
//     offset            two's-complement displacement for BRA
//     skip_cond         SKIP condition
//     int_req, int_en   level interrupt request and global enable
//     clr_err           clears the sticky stack error flags
//     pc                registered program counter
//     flush             pulse while a non-sequential pc is first visible
//     level             occupied stack entries, 0..DEPTH
//     int_active        interrupt service in progress
//     stack_ovf/unf     sticky push-while-full / pop-while-empty flags
module program_flow_unit #(
  parameter int          PC_W      = 11,
  parameter int          DEPTH     = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned INT_VEC   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic [PC_W-1:0]            target,
  input  logic [PC_W-1:0]            offset,
  input  logic                       skip_cond,
  input  logic                       int_req,
  input  logic                       int_en,
  input  logic                       clr_err,
  output logic [PC_W-1:0]            pc,
  output logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       int_active,
  output logic                       stack_ovf,
  output logic                       stack_unf
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int SP_W  = $clog2(DEPTH);
  localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0]  INT_PC   = PC_W'(INT_VEC);
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    CMD_NEXT   = 3'd0,
    CMD_GOTO   = 3'd1,
    CMD_CALL   = 3'd2,
    CMD_RETURN = 3'd3,
    CMD_BRA    = 3'd4,
    CMD_SKIP   = 3'd5,
    CMD_RETFIE = 3'd6,
    CMD_RSVD   = 3'd7
  } cmd_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SP_W-1:0]  sp_q, sp_d;   // next free slot; wraps so a full push lands on the oldest entry
  logic             int_active_q, int_active_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PC_W-1:0]  stack_mem [DEPTH];
  logic [PC_W-1:0]  top_entry;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  seq_pc;       // next pc of a non-stack command, before any interrupt
  logic             seq_flush;
  logic             take_int;
  logic             push;
  logic             pop;
  logic [PC_W-1:0]  push_data;
  cmd_e             cmd_op;

  assign cmd_op    = cmd_e'(cmd);
  assign pc_inc    = pc_q + PC_W'(1);
  assign top_entry = stack_mem[sp_q - SP_W'(1)];

  always_comb begin
    seq_pc    = pc_inc;
    seq_flush = 1'b0;
    case (cmd_op)
      CMD_GOTO: begin
        seq_pc    = target;
        seq_flush = 1'b1;
      end
      CMD_BRA: begin
        seq_pc    = pc_inc + offset;
        seq_flush = 1'b1;
      end
      CMD_SKIP: begin
        seq_pc    = skip_cond ? (pc_q + PC_W'(2)) : pc_inc;
        seq_flush = skip_cond;
      end
      default: begin
        seq_pc    = pc_inc;
        seq_flush = 1'b0;
      end
    endcase
  end

  // Stack-touching commands defer a pending interrupt to the next command.
  assign take_int = cmd_valid && int_req && int_en && !int_active_q &&
                    (cmd_op != CMD_CALL) && (cmd_op != CMD_RETURN) &&
                    (cmd_op != CMD_RETFIE);

  always_comb begin
    pc_d         = pc_q;
    flush_d      = 1'b0;
    level_d      = level_q;
    sp_d         = sp_q;
    int_active_d = int_active_q;
    // A set event later in this block overrides the clear.
    ovf_d        = ovf_q && !clr_err;
    unf_d        = unf_q && !clr_err;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = pc_inc;

    if (cmd_valid) begin
      case (cmd_op)
        CMD_CALL: begin
          push      = 1'b1;
          push_data = pc_inc;
          pc_d      = target;
          flush_d   = 1'b1;
        end
        CMD_RETURN: pop = 1'b1;
        CMD_RETFIE: begin
          pop          = 1'b1;
          int_active_d = 1'b0;
        end
        default: begin
          if (take_int) begin
            push         = 1'b1;
            push_data    = seq_pc;
            pc_d         = INT_PC;
            int_active_d = 1'b1;
            flush_d      = 1'b1;
          end else begin
            pc_d    = seq_pc;
            flush_d = seq_flush;
          end
        end
      endcase
    end

    if (push) begin
      sp_d = sp_q + SP_W'(1);
      if (level_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        level_d = level_q + LVL_W'(1);
      end
    end

    if (pop) begin
      flush_d = 1'b1;
      if (level_q == '0) begin
        pc_d  = RESET_PC;
        unf_d = 1'b1;
      end else begin
        pc_d    = top_entry;
        sp_d    = sp_q - SP_W'(1);
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      level_q      <= '0;
      sp_q         <= '0;
      int_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      level_q      <= level_d;
      sp_q         <= sp_d;
      int_active_q <= int_active_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Stack storage carries no reset; only the pointer and level are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_mem[sp_q] <= push_data;
    end
  end

  assign pc         = pc_q;
  assign flush      = flush_q;
  assign level      = level_q;
  assign int_active = int_active_q;
  assign stack_ovf  = ovf_q;
  assign stack_unf  = unf_q;

endmodule
